// File: rtl/rsa_job_sequencer.sv
// Job front-end for the RSA control datapath: accepts one job, sequences the inverter and
// exponentiation phases with guarded finish detection and timeout, and returns the result.
module rsa_job_sequencer #(
   parameter int WIDTH   = 128,
   parameter int GUARD   = 2,
   parameter int TIMEOUT = 65535
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [WIDTH-1:0]   job_p,
   input  logic [WIDTH-1:0]   job_q,
   input  logic               job_encrypt_decrypt,
   input  logic [2*WIDTH-1:0] job_msg,
   output logic [WIDTH-1:0]   ctl_p,
   output logic [WIDTH-1:0]   ctl_q,
   output logic               ctl_encrypt_decrypt,
   output logic [2*WIDTH-1:0] ctl_msg,
   output logic               ctl_reset_inverter,
   output logic               ctl_reset_mod_exp,
   input  logic               ctl_inverter_finish,
   input  logic               ctl_mod_exp_finish,
   input  logic [2*WIDTH-1:0] ctl_msg_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_msg,
   output logic               res_err,
   output logic               key_hit
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INV_PULSE,
      S_INV_WAIT,
      S_EXP_PULSE,
      S_EXP_WAIT,
      S_RESULT
   } state_t;

   localparam logic [15:0] GUARD_C    = 16'(GUARD);
   localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]     p_q, p_d, q_q, q_d;
   logic                 ed_q, ed_d;
   logic [2*WIDTH-1:0]   msg_q, msg_d;
   logic [WIDTH-1:0]     cache_p_q, cache_p_d, cache_q_q, cache_q_d;
   logic                 cache_vld_q, cache_vld_d;
   logic [2*WIDTH-1:0]   res_msg_q, res_msg_d;
   logic                 res_err_q, res_err_d;
   logic                 key_hit_q, key_hit_d;

   logic                 key_match;
   logic                 guard_ok;
   logic                 last_wait;

   assign key_match = cache_vld_q && (job_p == cache_p_q) && (job_q == cache_q_q);
   // Finish may still be high from the previous job; trust it only after the guard window.
   assign guard_ok  = (cnt_q >= GUARD_C);
   assign last_wait = (cnt_q == TMO_LAST_C);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         p_q         <= '0;
         q_q         <= '0;
         ed_q        <= 1'b0;
         msg_q       <= '0;
         cache_p_q   <= '0;
         cache_q_q   <= '0;
         cache_vld_q <= 1'b0;
         res_msg_q   <= '0;
         res_err_q   <= 1'b0;
         key_hit_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         q_q         <= q_d;
         ed_q        <= ed_d;
         msg_q       <= msg_d;
         cache_p_q   <= cache_p_d;
         cache_q_q   <= cache_q_d;
         cache_vld_q <= cache_vld_d;
         res_msg_q   <= res_msg_d;
         res_err_q   <= res_err_d;
         key_hit_q   <= key_hit_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      p_d         = p_q;
      q_d         = q_q;
      ed_d        = ed_q;
      msg_d       = msg_q;
      cache_p_d   = cache_p_q;
      cache_q_d   = cache_q_q;
      cache_vld_d = cache_vld_q;
      res_msg_d   = res_msg_q;
      res_err_d   = res_err_q;
      key_hit_d   = key_hit_q;

      unique case (state_q)
         S_IDLE: begin
            if (job_valid) begin
               p_d       = job_p;
               q_d       = job_q;
               ed_d      = job_encrypt_decrypt;
               msg_d     = job_msg;
               key_hit_d = key_match;
               state_d   = key_match ? S_EXP_PULSE : S_INV_PULSE;
            end
         end
         S_INV_PULSE: begin
            cnt_d   = '0;
            state_d = S_INV_WAIT;
         end
         S_INV_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (guard_ok && ctl_inverter_finish) begin
               cache_p_d   = p_q;
               cache_q_d   = q_q;
               cache_vld_d = 1'b1;
               state_d     = S_EXP_PULSE;
            end else if (last_wait) begin
               cache_vld_d = 1'b0;
               res_err_d   = 1'b1;
               res_msg_d   = '0;
               state_d     = S_RESULT;
            end
         end
         S_EXP_PULSE: begin
            cnt_d   = '0;
            state_d = S_EXP_WAIT;
         end
         S_EXP_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (guard_ok && ctl_mod_exp_finish) begin
               res_err_d = 1'b0;
               res_msg_d = ctl_msg_out;
               state_d   = S_RESULT;
            end else if (last_wait) begin
               cache_vld_d = 1'b0;
               res_err_d   = 1'b1;
               res_msg_d   = '0;
               state_d     = S_RESULT;
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign job_ready           = (state_q == S_IDLE);
   assign ctl_reset_inverter  = (state_q == S_INV_PULSE);
   assign ctl_reset_mod_exp   = (state_q == S_EXP_PULSE);
   assign res_valid           = (state_q == S_RESULT);
   assign ctl_p               = p_q;
   assign ctl_q               = q_q;
   assign ctl_encrypt_decrypt = ed_q;
   assign ctl_msg             = msg_q;
   assign res_msg             = res_msg_q;
   assign res_err             = res_err_q;
   assign key_hit             = key_hit_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Scoreboard bench for rsa_job_sequencer: a cycle-stepped control model answers the
// reset pulses, expected results are queued at job issue and compared on res_valid.
module tb_rsa_job_sequencer;
   localparam int W      = 128;
   localparam int GUARD  = 2;
   localparam int TMO    = 20;
   localparam int BUDGET = 200;

   localparam logic [W-1:0]   P1 = 128'd113680897410347;
   localparam logic [W-1:0]   Q1 = 128'd7999808077935876437321;
   localparam logic [W-1:0]   P2 = 128'd1000000007;
   localparam logic [W-1:0]   Q2 = 128'd998244353;
   localparam logic [W-1:0]   P3 = 128'd65537;
   localparam logic [W-1:0]   Q3 = 128'd257;
   localparam logic [2*W-1:0] M1 = 256'h00262d806a3e18f03ab37b2857e7e149;
   localparam logic [2*W-1:0] M2 = 256'h08e2a11b5e2b4d0e3f7795ebe2596d9d;

   logic           clk = 1'b0;
   logic           reset;
   logic           job_valid, job_ready;
   logic [W-1:0]   job_p, job_q;
   logic           job_encrypt_decrypt;
   logic [2*W-1:0] job_msg;
   logic [W-1:0]   ctl_p, ctl_q;
   logic           ctl_encrypt_decrypt;
   logic [2*W-1:0] ctl_msg;
   logic           ctl_reset_inverter, ctl_reset_mod_exp;
   logic           ctl_inverter_finish, ctl_mod_exp_finish;
   logic [2*W-1:0] ctl_msg_out;
   logic           res_valid, res_ready;
   logic [2*W-1:0] res_msg;
   logic           res_err, key_hit;

   rsa_job_sequencer #(.WIDTH(W), .GUARD(GUARD), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_p(job_p), .job_q(job_q),
      .job_encrypt_decrypt(job_encrypt_decrypt), .job_msg(job_msg),
      .ctl_p(ctl_p), .ctl_q(ctl_q),
      .ctl_encrypt_decrypt(ctl_encrypt_decrypt), .ctl_msg(ctl_msg),
      .ctl_reset_inverter(ctl_reset_inverter), .ctl_reset_mod_exp(ctl_reset_mod_exp),
      .ctl_inverter_finish(ctl_inverter_finish), .ctl_mod_exp_finish(ctl_mod_exp_finish),
      .ctl_msg_out(ctl_msg_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_msg(res_msg), .res_err(res_err), .key_hit(key_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] msg;
      logic           err;
      logic           hit;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Observations of the last job, cycle numbers counted from the accept edge (1 = T+1).
   int             obs_inv, obs_exp, obs_inv_c, obs_exp_c, obs_res_c;
   logic           obs_done, obs_ready_seen;
   logic [2*W-1:0] obs_msg;
   logic           obs_err, obs_hit;

   // Issue one job and act as the control block until res_valid; a delay of -1 never finishes.
   task automatic do_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic ed,
                         input logic [2*W-1:0] msg, input logic [2*W-1:0] out_val,
                         input int inv_dly, input int exp_dly, input logic hold_fin,
                         input logic exp_hit, input logic exp_err);
      exp_t e;
      int   inv_k, exp_k;
      e.msg = exp_err ? '0 : out_val;
      e.err = exp_err;
      e.hit = exp_hit;
      sb_q.push_back(e);
      obs_inv = 0; obs_exp = 0; obs_inv_c = -1; obs_exp_c = -1; obs_res_c = -1;
      obs_done = 1'b0; obs_ready_seen = 1'b0;
      obs_msg = '0; obs_err = 1'b0; obs_hit = 1'b0;
      inv_k = -1; exp_k = -1;
      ctl_msg_out = ~out_val;
      job_p = p; job_q = q; job_encrypt_decrypt = ed; job_msg = msg;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      job_p = ~p; job_q = ~q; job_msg = ~msg; job_encrypt_decrypt = ~ed;
      for (int c = 1; c <= BUDGET && !obs_done; c++) begin
         if (c > 1) @(negedge clk);
         if (job_ready) obs_ready_seen = 1'b1;
         if (ctl_reset_inverter) begin
            obs_inv++;
            if (obs_inv_c < 0) obs_inv_c = c;
            inv_k = 0;
            if (!hold_fin) ctl_inverter_finish = 1'b0;
         end else if (inv_k >= 0) begin
            inv_k++;
         end
         if (ctl_reset_mod_exp) begin
            obs_exp++;
            if (obs_exp_c < 0) obs_exp_c = c;
            exp_k = 0;
            ctl_msg_out = out_val;
            if (!hold_fin) ctl_mod_exp_finish = 1'b0;
         end else if (exp_k >= 0) begin
            exp_k++;
         end
         if (inv_dly >= 0 && inv_k >= inv_dly) ctl_inverter_finish = 1'b1;
         if (exp_dly >= 0 && exp_k >= exp_dly) ctl_mod_exp_finish = 1'b1;
         if (res_valid) begin
            obs_done  = 1'b1;
            obs_res_c = c;
            obs_msg   = res_msg;
            obs_err   = res_err;
            obs_hit   = key_hit;
         end
      end
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; job_valid = 1'b0; res_ready = 1'b0;
      job_p = '0; job_q = '0; job_encrypt_decrypt = 1'b0; job_msg = '0;
      ctl_inverter_finish = 1'b0; ctl_mod_exp_finish = 1'b0; ctl_msg_out = '0;
      repeat (3) @(negedge clk);
      n_vec++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
      n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      n_vec++; if ({ctl_reset_inverter, ctl_reset_mod_exp} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b%b want 00", ctl_reset_inverter, ctl_reset_mod_exp); end
      n_vec++; if ({ctl_p, ctl_q} !== '0) begin n_bad++; $display("FAIL reset_ctl_pq: got %h/%h want 0", ctl_p, ctl_q); end
      n_vec++; if (ctl_msg !== '0) begin n_bad++; $display("FAIL reset_ctl_msg: got %h want 0", ctl_msg); end
      n_vec++; if (res_msg !== '0) begin n_bad++; $display("FAIL reset_res_msg: got %h want 0", res_msg); end
      n_vec++; if ({res_err, key_hit} !== 2'b00) begin n_bad++; $display("FAIL reset_err_hit: got %b%b want 00", res_err, key_hit); end
      reset = 1'b0;
      @(negedge clk);
      n_vec++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL idle_job_ready: got %b want 1", job_ready); end
   endtask

   task automatic test_encrypt();
      exp_t e;
      do_job(P1, Q1, 1'b0, M1, 256'h5a5a_0001_dead_beef_0123_4567_89ab_cdef, 3, 3, 1'b0, 1'b0, 1'b0);
      n_vec++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL enc_done: got %b want 1", obs_done); end
      n_vec++; if (obs_inv != 1 || obs_inv_c != 1) begin n_bad++; $display("FAIL enc_inv_pulse: got %0d pulses at %0d want 1 at 1", obs_inv, obs_inv_c); end
      n_vec++; if (obs_exp != 1 || obs_exp_c != 5) begin n_bad++; $display("FAIL enc_exp_pulse: got %0d pulses at %0d want 1 at 5", obs_exp, obs_exp_c); end
      n_vec++; if (obs_res_c != 9) begin n_bad++; $display("FAIL enc_res_cycle: got %0d want 9", obs_res_c); end
      n_vec++; if (obs_ready_seen !== 1'b0) begin n_bad++; $display("FAIL enc_job_ready_busy: got %b want 0", obs_ready_seen); end
      n_vec++; if (ctl_p !== P1 || ctl_q !== Q1) begin n_bad++; $display("FAIL enc_ctl_pq: got %h/%h want %h/%h", ctl_p, ctl_q, P1, Q1); end
      n_vec++; if (ctl_encrypt_decrypt !== 1'b0 || ctl_msg !== M1) begin n_bad++; $display("FAIL enc_ctl_msg: got %b/%h want 0/%h", ctl_encrypt_decrypt, ctl_msg, M1); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg) begin n_bad++; $display("FAIL enc_res_msg: got %h want %h", obs_msg, e.msg); end
      n_vec++; if (obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL enc_err_hit: got %b%b want %b%b", obs_err, obs_hit, e.err, e.hit); end
      take_result();
      n_vec++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin n_bad++; $display("FAIL enc_release: got valid=%b ready=%b want 0/1", res_valid, job_ready); end
   endtask

   task automatic test_key_hit();
      exp_t e;
      do_job(P1, Q1, 1'b1, M2, 256'h0bad_cafe_0000_1111_2222_3333_4444_5555, 3, 3, 1'b0, 1'b1, 1'b0);
      n_vec++; if (obs_inv != 0) begin n_bad++; $display("FAIL hit_no_inv: got %0d pulses want 0", obs_inv); end
      n_vec++; if (obs_exp != 1 || obs_exp_c != 1) begin n_bad++; $display("FAIL hit_exp_pulse: got %0d at %0d want 1 at 1", obs_exp, obs_exp_c); end
      n_vec++; if (obs_res_c != 5) begin n_bad++; $display("FAIL hit_res_cycle: got %0d want 5", obs_res_c); end
      n_vec++; if (ctl_encrypt_decrypt !== 1'b1 || ctl_msg !== M2) begin n_bad++; $display("FAIL hit_ctl_msg: got %b/%h want 1/%h", ctl_encrypt_decrypt, ctl_msg, M2); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL hit_result: got %h/%b/%b want %h/%b/%b", obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
      take_result();
   endtask

   task automatic test_stale_finish();
      exp_t e;
      // Exponentiation finish left high by the previous job.
      do_job(P1, Q1, 1'b0, M1, 256'h7777_aaaa_5555_cccc, 0, 0, 1'b1, 1'b1, 1'b0);
      n_vec++; if (obs_exp_c != 1 || obs_res_c != 2 + 2 + GUARD - 1) begin n_bad++; $display("FAIL stale_exp_guard: got pulse %0d result %0d want 1/5", obs_exp_c, obs_res_c); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL stale_exp_result: got %h/%b/%b want %h/%b/%b", obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
      take_result();
      // Both finishes stale-high on a new key: each phase must sit out its guard window.
      do_job(P2, Q2, 1'b1, M2, 256'h1357_9bdf_2468_ace0, 0, 0, 1'b1, 1'b0, 1'b0);
      n_vec++; if (obs_inv_c != 1 || obs_exp_c != 5 || obs_res_c != 9) begin n_bad++; $display("FAIL stale_both_guard: got %0d/%0d/%0d want 1/5/9", obs_inv_c, obs_exp_c, obs_res_c); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL stale_both_result: got %h/%b/%b want %h/%b/%b", obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
      take_result();
   endtask

   task automatic test_timeout();
      exp_t e;
      do_job(P2, Q2, 1'b0, M1, 256'hffff_0000_ffff_0000, 3, -1, 1'b0, 1'b1, 1'b1);
      n_vec++; if (obs_exp_c != 1 || obs_res_c - obs_exp_c != TMO + 1) begin n_bad++; $display("FAIL tmo_exp_latency: got pulse %0d result %0d want 1/%0d", obs_exp_c, obs_res_c, TMO + 2); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL tmo_exp_result: got %h/%b/%b want %h/%b/%b", obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
      take_result();
      do_job(P2, Q2, 1'b0, M2, 256'h0123_3210, 3, 3, 1'b0, 1'b0, 1'b0);
      n_vec++; if (obs_inv != 1) begin n_bad++; $display("FAIL tmo_exp_recache: got %0d inverter pulses want 1", obs_inv); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL tmo_recache_result: got %h/%b/%b want %h/%b/%b", obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
      take_result();
      do_job(P3, Q3, 1'b1, M1, 256'h4444, -1, 3, 1'b0, 1'b0, 1'b1);
      n_vec++; if (obs_inv_c != 1 || obs_exp != 0 || obs_res_c != TMO + 2) begin n_bad++; $display("FAIL tmo_inv_latency: got %0d/%0d/%0d want 1/0/%0d", obs_inv_c, obs_exp, obs_res_c, TMO + 2); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL tmo_inv_result: got %h/%b/%b want %h/%b/%b", obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
      take_result();
      // The inverter timeout dropped the P2/Q2 entry too.
      do_job(P2, Q2, 1'b0, M2, 256'h9999_8888, 3, 3, 1'b0, 1'b0, 1'b0);
      n_vec++; if (obs_inv != 1 || obs_hit !== 1'b0) begin n_bad++; $display("FAIL tmo_inv_invalidate: got %0d pulses hit=%b want 1/0", obs_inv, obs_hit); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err) begin n_bad++; $display("FAIL tmo_after_result: got %h/%b want %h/%b", obs_msg, obs_err, e.msg, e.err); end
      take_result();
   endtask

   task automatic test_backpressure();
      exp_t e;
      do_job(P1, Q1, 1'b1, M1, 256'hbeef_f00d_c0de_0042, 3, 3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if (res_valid !== 1'b1 || job_ready !== 1'b0 || res_msg !== obs_msg ||
             res_err !== obs_err || key_hit !== obs_hit) begin
            n_bad++;
            $display("FAIL bp_hold_%0d: got valid=%b ready=%b msg=%h err=%b hit=%b want 1/0/%h/%b/%b",
                     i, res_valid, job_ready, res_msg, res_err, key_hit, obs_msg, obs_err, obs_hit);
         end
      end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL bp_result: got %h/%b/%b want %h/%b/%b", obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
      take_result();
      n_vec++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", res_valid, job_ready); end
   endtask

   task automatic test_reset_mid_job();
      exp_t e;
      ctl_mod_exp_finish = 1'b0;
      job_p = P1; job_q = Q1; job_encrypt_decrypt = 1'b0; job_msg = M2;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      n_vec++; if (ctl_reset_mod_exp !== 1'b1) begin n_bad++; $display("FAIL rst_pre_hit: got exp pulse %b want 1", ctl_reset_mod_exp); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++; if (job_ready !== 1'b1 || res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: got ready=%b valid=%b want 1/0", job_ready, res_valid); end
      n_vec++; if (ctl_p !== '0 || ctl_msg !== '0 || res_msg !== '0) begin n_bad++; $display("FAIL rst_mid_regs: got %h/%h/%h want 0", ctl_p, ctl_msg, res_msg); end
      ctl_mod_exp_finish = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin n_bad++; $display("FAIL rst_no_result: got valid=%b ready=%b want 0/1", res_valid, job_ready); end
      do_job(P1, Q1, 1'b0, M2, 256'h6060_0606, 3, 3, 1'b0, 1'b0, 1'b0);
      n_vec++; if (obs_inv != 1 || obs_hit !== 1'b0) begin n_bad++; $display("FAIL rst_cache_cleared: got %0d pulses hit=%b want 1/0", obs_inv, obs_hit); end
      e = sb_q.pop_front();
      n_vec++; if (obs_msg !== e.msg || obs_err !== e.err) begin n_bad++; $display("FAIL rst_after_result: got %h/%b want %h/%b", obs_msg, obs_err, e.msg, e.err); end
      take_result();
   endtask

   task automatic test_back_to_back();
      exp_t           e;
      logic           bk_vld;
      logic [W-1:0]   bk_p, bk_q, kp, kq;
      logic [2*W-1:0] m, r;
      logic           hit;
      int             pick [6] = '{0, 0, 1, 1, 0, 1};
      bk_vld = 1'b1; bk_p = P1; bk_q = Q1;
      for (int i = 0; i < 6; i++) begin
         kp  = (pick[i] == 0) ? P1 : P2;
         kq  = (pick[i] == 0) ? Q1 : Q2;
         hit = bk_vld && kp == bk_p && kq == bk_q;
         m   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         r   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         do_job(kp, kq, i[0], m, r, 2 + i, 3 + i, 1'b0, hit, 1'b0);
         if (!hit) begin bk_vld = 1'b1; bk_p = kp; bk_q = kq; end
         n_vec++; if (obs_inv != (hit ? 0 : 1)) begin n_bad++; $display("FAIL b2b_%0d_path: got %0d inverter pulses want %0d", i, obs_inv, hit ? 0 : 1); end
         n_vec++; if (ctl_msg !== m || ctl_encrypt_decrypt !== i[0]) begin n_bad++; $display("FAIL b2b_%0d_ctl: got %h/%b want %h/%b", i, ctl_msg, ctl_encrypt_decrypt, m, i[0]); end
         e = sb_q.pop_front();
         n_vec++; if (obs_msg !== e.msg || obs_err !== e.err || obs_hit !== e.hit) begin n_bad++; $display("FAIL b2b_%0d_result: got %h/%b/%b want %h/%b/%b", i, obs_msg, obs_err, obs_hit, e.msg, e.err, e.hit); end
         take_result();
      end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_key_hit();
      test_stale_finish();
      test_timeout();
      test_backpressure();
      test_reset_mid_job();
      test_back_to_back();
      n_vec++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d pending want 0", sb_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
